// File: rtl/btb_assoc_if.sv
// btb_assoc_if: fetch lookup and execute resolution bundle
// for the set-associative branch target buffer.
interface btb_assoc_if #(
  parameter int XLEN     = 32,
  parameter int WAY_BITS = 1
);
  logic                lookup_i;
  logic [XLEN-1:0]     pc_i;
  logic                valid_i;
  logic                del_entry_i;
  logic [XLEN-1:0]     res_pc_i;
  logic [XLEN-1:0]     res_target_i;
  logic                hit_o;
  logic [WAY_BITS-1:0] hit_way_o;
  logic [XLEN-1:0]     pred_target_o;

  modport master (
    output lookup_i, pc_i, valid_i,
    output del_entry_i, res_pc_i, res_target_i,
    input  hit_o, hit_way_o, pred_target_o
  );

  modport slave (
    input  lookup_i, pc_i, valid_i,
    input  del_entry_i, res_pc_i, res_target_i,
    output hit_o, hit_way_o, pred_target_o
  );
endinterface

// File: rtl/btb_assoc.sv
// btb_assoc: set-associative BTB, round-robin per set,
// registered lookup. Optional macro BTB_BYPASS_EN.
package mmm_pkg;
  localparam int XLEN   = 32;
  localparam int OFFSET = 2;
endpackage

module btb_assoc #(
  parameter int XLEN     = mmm_pkg::XLEN,
  parameter int OFFSET   = mmm_pkg::OFFSET,
  parameter int IDX_BITS = 4,
  parameter int WAYS     = 2
) (
  input logic       clk_i,
  input logic       rst_n_i,
  input logic       flush_i,
  btb_assoc_if.slave bus
);
  localparam int SETS     = 2**IDX_BITS;
  localparam int WAY_BITS = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int TAG_BITS = XLEN - IDX_BITS - OFFSET;
  localparam int TGT_BITS = XLEN - OFFSET;
`ifdef BTB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic [WAYS-1:0]     vld_q [SETS];
  logic [TAG_BITS-1:0] tag_q [SETS][WAYS];
  logic [TGT_BITS-1:0] tgt_q [SETS][WAYS];
  logic [WAY_BITS-1:0] rr_q  [SETS];

  logic [IDX_BITS-1:0] lidx, ridx;
  logic [TAG_BITS-1:0] ltag, rtag;
  logic                l_hit, r_hit, inv_any;
  logic [WAY_BITS-1:0] l_way, r_way, inv_way, v_way;
  logic                wr_en, del_en, rr_inc, byp_en;
  logic                unused;

  assign lidx = bus.pc_i[IDX_BITS+OFFSET-1:OFFSET];
  assign ltag = bus.pc_i[XLEN-1:IDX_BITS+OFFSET];
  assign ridx = bus.res_pc_i[IDX_BITS+OFFSET-1:OFFSET];
  assign rtag = bus.res_pc_i[XLEN-1:IDX_BITS+OFFSET];
  assign unused = ^{bus.pc_i[OFFSET-1:0],
                    bus.res_pc_i[OFFSET-1:0],
                    bus.res_target_i[OFFSET-1:0]};

  // Tag compare for both ports; downward scan lets way 0 win.
  always_comb begin
    l_hit   = 1'b0;
    l_way   = '0;
    r_hit   = 1'b0;
    r_way   = '0;
    inv_any = 1'b0;
    inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (vld_q[lidx][w] && tag_q[lidx][w] == ltag) begin
        l_hit = 1'b1;
        l_way = WAY_BITS'(w);
      end
      if (vld_q[ridx][w] && tag_q[ridx][w] == rtag) begin
        r_hit = 1'b1;
        r_way = WAY_BITS'(w);
      end
      if (!vld_q[ridx][w]) begin
        inv_any = 1'b1;
        inv_way = WAY_BITS'(w);
      end
    end
  end

  // Victim choice: matching way, then free way, then rr.
  always_comb begin
    v_way  = r_hit ? r_way : (inv_any ? inv_way : rr_q[ridx]);
    wr_en  = bus.valid_i && !bus.del_entry_i && !flush_i;
    del_en = bus.valid_i && bus.del_entry_i && r_hit && !flush_i;
    rr_inc = wr_en && !r_hit && !inv_any && (WAYS > 1);
    byp_en = BYPASS && bus.lookup_i && bus.valid_i &&
             (bus.pc_i[XLEN-1:OFFSET] == bus.res_pc_i[XLEN-1:OFFSET]);
  end

  // Table storage: clear on reset/flush, else update or delete.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int s = 0; s < SETS; s++) begin
        vld_q[s] <= '0;
        rr_q[s]  <= '0;
        for (int w = 0; w < WAYS; w++) begin
          tag_q[s][w] <= '0;
          tgt_q[s][w] <= '0;
        end
      end
    end else if (flush_i) begin
      for (int s = 0; s < SETS; s++) begin
        vld_q[s] <= '0;
        rr_q[s]  <= '0;
        for (int w = 0; w < WAYS; w++) begin
          tag_q[s][w] <= '0;
          tgt_q[s][w] <= '0;
        end
      end
    end else begin
      if (del_en) begin
        vld_q[ridx][r_way] <= 1'b0;
        tag_q[ridx][r_way] <= '0;
        tgt_q[ridx][r_way] <= '0;
      end
      if (wr_en) begin
        vld_q[ridx][v_way] <= 1'b1;
        tag_q[ridx][v_way] <= rtag;
        tgt_q[ridx][v_way] <= bus.res_target_i[XLEN-1:OFFSET];
      end
      if (rr_inc) begin
        rr_q[ridx] <= rr_q[ridx] + 1'b1;
      end
    end
  end

  // Registered prediction, optionally forwarding the resolution.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      bus.hit_o         <= 1'b0;
      bus.hit_way_o     <= '0;
      bus.pred_target_o <= '0;
    end else if (flush_i) begin
      bus.hit_o         <= 1'b0;
      bus.hit_way_o     <= '0;
      bus.pred_target_o <= '0;
    end else if (byp_en && !bus.del_entry_i) begin
      bus.hit_o         <= 1'b1;
      bus.hit_way_o     <= v_way;
      bus.pred_target_o <= {bus.res_target_i[XLEN-1:OFFSET],
                            {OFFSET{1'b0}}};
    end else if (bus.lookup_i && l_hit && !byp_en) begin
      bus.hit_o         <= 1'b1;
      bus.hit_way_o     <= l_way;
      bus.pred_target_o <= {tgt_q[lidx][l_way], {OFFSET{1'b0}}};
    end else begin
      bus.hit_o         <= 1'b0;
      bus.hit_way_o     <= '0;
      bus.pred_target_o <= '0;
    end
  end
endmodule

// File: tb/tb_btb_assoc.sv
// tb_btb_assoc: directed and random checks of btb_assoc
// against an array-based table model (2 ways, 16 sets).
module tb_btb_assoc;
  logic clk;
  logic rst_n;
  logic flush;

  btb_assoc_if #(.XLEN(32), .WAY_BITS(1)) bif ();

  btb_assoc #(
    .XLEN(32), .OFFSET(2), .IDX_BITS(4), .WAYS(2)
  ) dut (
    .clk_i(clk),
    .rst_n_i(rst_n),
    .flush_i(flush),
    .bus(bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  bit          m_vld [16][2];
  int unsigned m_tag [16][2];
  logic [31:0] m_tgt [16][2];
  int          m_rr  [16];

  logic        e_hit;
  logic        e_way;
  logic [31:0] e_tgt;

  function automatic void model_clear();
    for (int s = 0; s < 16; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < 2; w++) begin
        m_vld[s][w] = 0;
        m_tag[s][w] = 0;
        m_tgt[s][w] = 0;
      end
    end
  endfunction

  function automatic int find(int s, int unsigned t);
    for (int w = 0; w < 2; w++)
      if (m_vld[s][w] && m_tag[s][w] == t) return w;
    return -1;
  endfunction

  task automatic drv(input bit lk, input logic [31:0] pc,
                     input bit v, input bit d,
                     input logic [31:0] rp, input logic [31:0] rt,
                     input bit fl);
    bif.lookup_i     = lk;
    bif.pc_i         = pc;
    bif.valid_i      = v;
    bif.del_entry_i  = d;
    bif.res_pc_i     = rp;
    bif.res_target_i = rt;
    flush            = fl;
  endtask

  // One clock: model consumes the inputs seen at the edge.
  task automatic step();
    int li, ri, w, rw;
    int unsigned lt, rtg;
    @(posedge clk);
    li  = int'((bif.pc_i >> 2) % 16);
    lt  = bif.pc_i >> 6;
    ri  = int'((bif.res_pc_i >> 2) % 16);
    rtg = bif.res_pc_i >> 6;
    e_hit = 0; e_way = 0; e_tgt = 0;
    if (flush) begin
      model_clear();
    end else begin
      w = find(li, lt);
      if (bif.lookup_i && w >= 0) begin
        e_hit = 1; e_way = w[0]; e_tgt = m_tgt[li][w];
      end
      if (bif.valid_i) begin
        rw = find(ri, rtg);
        if (bif.del_entry_i) begin
          if (rw >= 0) begin
            m_vld[ri][rw] = 0; m_tag[ri][rw] = 0; m_tgt[ri][rw] = 0;
          end
        end else begin
          if (rw < 0) begin
            if (!m_vld[ri][0]) rw = 0;
            else if (!m_vld[ri][1]) rw = 1;
            else begin
              rw = m_rr[ri];
              m_rr[ri] = (m_rr[ri] + 1) % 2;
            end
          end
          m_vld[ri][rw] = 1;
          m_tag[ri][rw] = rtg;
          m_tgt[ri][rw] = bif.res_target_i & ~32'h3;
        end
`ifdef BTB_BYPASS_EN
        if (bif.lookup_i && (bif.pc_i >> 2) == (bif.res_pc_i >> 2)) begin
          e_hit = 0; e_way = 0; e_tgt = 0;
          if (!bif.del_entry_i) begin
            e_hit = 1; e_way = rw[0]; e_tgt = bif.res_target_i & ~32'h3;
          end
        end
`endif
      end
    end
    #1;
  endtask

  task automatic upd(input logic [31:0] rp, input logic [31:0] rt);
    drv(0, 0, 1, 0, rp, rt, 0); step();
  endtask

  task automatic look(input logic [31:0] pc);
    drv(1, pc, 0, 0, 0, 0, 0); step();
  endtask

  task automatic test_reset();
    rst_n = 0;
    drv(0, 0, 0, 0, 0, 0, 0);
    model_clear();
    #12;
    n_chk++;
    if (bif.hit_o !== 1'b0 || bif.hit_way_o !== 1'b0 ||
        bif.pred_target_o !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got hit=%b way=%b tgt=%h, want 0 0 0",
               bif.hit_o, bif.hit_way_o, bif.pred_target_o);
    end
    rst_n = 1;
    look(32'h100);
    n_chk++;
    if (bif.hit_o !== 1'b0 || bif.pred_target_o !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_lookup: got hit=%b tgt=%h, want 0 0",
               bif.hit_o, bif.pred_target_o);
    end
  endtask

  task automatic test_alloc();
    upd(32'h100, 32'h2003);
    look(32'h100);
    n_chk++;
    if (bif.hit_o !== 1'b1 || bif.hit_way_o !== 1'b0 ||
        bif.pred_target_o !== 32'h2000) begin
      n_fail++;
      $display("FAIL alloc_hit: got hit=%b way=%b tgt=%h, want 1 0 2000",
               bif.hit_o, bif.hit_way_o, bif.pred_target_o);
    end
    drv(0, 32'h100, 0, 0, 0, 0, 0); step();
    n_chk++;
    if (bif.hit_o !== 1'b0 || bif.pred_target_o !== 32'h0) begin
      n_fail++;
      $display("FAIL no_lookup: got hit=%b tgt=%h, want 0 0",
               bif.hit_o, bif.pred_target_o);
    end
  endtask

  task automatic test_replace();
    upd(32'h100, 32'h2000);
    upd(32'h140, 32'h3000);
    upd(32'h180, 32'h4000);
    look(32'h100);
    n_chk++;
    if (bif.hit_o !== 1'b0) begin
      n_fail++;
      $display("FAIL evict_100: got hit=%b, want 0", bif.hit_o);
    end
    look(32'h180);
    n_chk++;
    if (bif.hit_o !== 1'b1 || bif.hit_way_o !== 1'b0 ||
        bif.pred_target_o !== 32'h4000) begin
      n_fail++;
      $display("FAIL repl_180: got hit=%b way=%b tgt=%h, want 1 0 4000",
               bif.hit_o, bif.hit_way_o, bif.pred_target_o);
    end
    upd(32'h100, 32'h5000);
    look(32'h140);
    n_chk++;
    if (bif.hit_o !== 1'b0) begin
      n_fail++;
      $display("FAIL evict_140: got hit=%b, want 0", bif.hit_o);
    end
    look(32'h100);
    n_chk++;
    if (bif.hit_o !== 1'b1 || bif.hit_way_o !== 1'b1 ||
        bif.pred_target_o !== 32'h5000) begin
      n_fail++;
      $display("FAIL repl_100: got hit=%b way=%b tgt=%h, want 1 1 5000",
               bif.hit_o, bif.hit_way_o, bif.pred_target_o);
    end
  endtask

  task automatic test_overwrite();
    drv(0, 0, 0, 0, 0, 0, 1); step();
    upd(32'h100, 32'h2000);
    upd(32'h140, 32'h3000);
    upd(32'h140, 32'h3100);
    look(32'h140);
    n_chk++;
    if (bif.hit_o !== 1'b1 || bif.hit_way_o !== 1'b1 ||
        bif.pred_target_o !== 32'h3100) begin
      n_fail++;
      $display("FAIL overwrite: got hit=%b way=%b tgt=%h, want 1 1 3100",
               bif.hit_o, bif.hit_way_o, bif.pred_target_o);
    end
    upd(32'h180, 32'h4000);
    look(32'h180);
    n_chk++;
    if (bif.hit_o !== 1'b1 || bif.hit_way_o !== 1'b0 ||
        bif.pred_target_o !== 32'h4000) begin
      n_fail++;
      $display("FAIL rr_kept: got hit=%b way=%b tgt=%h, want 1 0 4000",
               bif.hit_o, bif.hit_way_o, bif.pred_target_o);
    end
  endtask

  task automatic test_delete();
    drv(0, 0, 1, 1, 32'h140, 0, 0); step();
    look(32'h140);
    n_chk++;
    if (bif.hit_o !== 1'b0) begin
      n_fail++;
      $display("FAIL delete_140: got hit=%b, want 0", bif.hit_o);
    end
    drv(0, 0, 1, 1, 32'h1C0, 0, 0); step();
    look(32'h180);
    n_chk++;
    if (bif.hit_o !== 1'b1 || bif.hit_way_o !== 1'b0 ||
        bif.pred_target_o !== 32'h4000) begin
      n_fail++;
      $display("FAIL delete_absent: got hit=%b way=%b tgt=%h, want 1 0 4000",
               bif.hit_o, bif.hit_way_o, bif.pred_target_o);
    end
    upd(32'h100, 32'h5000);
    look(32'h100);
    n_chk++;
    if (bif.hit_o !== 1'b1 || bif.hit_way_o !== 1'b1 ||
        bif.pred_target_o !== 32'h5000) begin
      n_fail++;
      $display("FAIL free_way: got hit=%b way=%b tgt=%h, want 1 1 5000",
               bif.hit_o, bif.hit_way_o, bif.pred_target_o);
    end
  endtask

  task automatic test_flush();
    drv(1, 32'h180, 1, 0, 32'h100, 32'h6000, 1); step();
    n_chk++;
    if (bif.hit_o !== 1'b0 || bif.pred_target_o !== 32'h0) begin
      n_fail++;
      $display("FAIL flush_out: got hit=%b tgt=%h, want 0 0",
               bif.hit_o, bif.pred_target_o);
    end
    look(32'h180);
    n_chk++;
    if (bif.hit_o !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_180: got hit=%b, want 0", bif.hit_o);
    end
    look(32'h100);
    n_chk++;
    if (bif.hit_o !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_100: got hit=%b, want 0", bif.hit_o);
    end
  endtask

  task automatic test_same_cycle();
    logic        x_hit;
    logic [31:0] x_tgt;
`ifdef BTB_BYPASS_EN
    x_hit = 1'b1; x_tgt = 32'h7000;
`else
    x_hit = 1'b0; x_tgt = 32'h0;
`endif
    drv(1, 32'h100, 1, 0, 32'h100, 32'h7000, 0); step();
    n_chk++;
    if (bif.hit_o !== x_hit || bif.hit_way_o !== 1'b0 ||
        bif.pred_target_o !== x_tgt) begin
      n_fail++;
      $display("FAIL same_cycle: got hit=%b way=%b tgt=%h, want %b 0 %h",
               bif.hit_o, bif.hit_way_o, bif.pred_target_o, x_hit, x_tgt);
    end
    look(32'h100);
    n_chk++;
    if (bif.hit_o !== 1'b1 || bif.hit_way_o !== 1'b0 ||
        bif.pred_target_o !== 32'h7000) begin
      n_fail++;
      $display("FAIL after_same: got hit=%b way=%b tgt=%h, want 1 0 7000",
               bif.hit_o, bif.hit_way_o, bif.pred_target_o);
    end
  endtask

  function automatic logic [31:0] rnd_pc();
    return ($urandom_range(0, 7) << 6) | ($urandom_range(0, 3) << 2) |
           $urandom_range(0, 3);
  endfunction

  task automatic test_random();
    logic [31:0] pc, rp;
    for (int i = 0; i < 400; i++) begin
      pc = rnd_pc();
      rp = ($urandom_range(0, 99) < 30) ? pc : rnd_pc();
      drv($urandom_range(0, 99) < 80, pc,
          $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 20,
          rp, $urandom, $urandom_range(0, 99) < 3);
      step();
      n_chk++;
      if (bif.hit_o !== e_hit || bif.hit_way_o !== e_way ||
          bif.pred_target_o !== e_tgt) begin
        n_fail++;
        $display("FAIL random[%0d]: got hit=%b way=%b tgt=%h, want %b %b %h",
                 i, bif.hit_o, bif.hit_way_o, bif.pred_target_o,
                 e_hit, e_way, e_tgt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_alloc();
    test_replace();
    test_overwrite();
    test_delete();
    test_flush();
    test_same_cycle();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
